// File: rtl/hilo_muldiv_ctrl_pkg.sv
// hilo_pkg: shared constants and types for the HI/LO multiply/divide sequencer.
//   FN_*          MIPS funct codes for the HI/LO instruction group
//   state_e       sequencer states
//   ITERS_DEF     default loop iteration count (operand width)
//   is_hilo_op()  true for any funct handled by the sequencer
package hilo_pkg;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  localparam int unsigned ITERS_DEF = 32;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

  function automatic logic is_hilo_op(input logic [5:0] fn);
    return (fn inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
                       FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
  endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// hilo_muldiv_ctrl_if: EXE-stage bus between the pipeline and the HI/LO sequencer.
//   master: pipeline side (drives instruction/operands/flush, sees results)
//   slave : sequencer side
interface hilo_muldiv_ctrl_if;
  logic        Valid_IN;
  logic [5:0]  ALUControl_IN;
  logic [31:0] OperandA_IN;
  logic [31:0] OperandB_IN;
  logic        Flush_IN;
  logic [31:0] Result_OUT;
  logic        Stall_OUT;
  logic        Busy_OUT;
  logic [31:0] HI_OUT;
  logic [31:0] LO_OUT;

  modport master (
    output Valid_IN, ALUControl_IN, OperandA_IN, OperandB_IN, Flush_IN,
    input  Result_OUT, Stall_OUT, Busy_OUT, HI_OUT, LO_OUT
  );

  modport slave (
    input  Valid_IN, ALUControl_IN, OperandA_IN, OperandB_IN, Flush_IN,
    output Result_OUT, Stall_OUT, Busy_OUT, HI_OUT, LO_OUT
  );
endinterface

// File: rtl/hilo_muldiv_ctrl_iter_core.sv
// muldiv_iter_core: one-bit-per-cycle unsigned shift-add multiply / restoring divide.
//   clk, rst_n  clock, async active-low reset
//   i_start     load operands (magnitudes) into the datapath
//   i_step      perform one iteration
//   i_is_div    select divide step instead of multiply step
//   i_op_a/b    multiplicand/dividend, multiplier/divisor magnitudes
//   o_prod      64-bit product; o_quo/o_rem quotient/remainder
// A single 64-bit register serves both ops: {hi_part, lo_part}. For multiply
// hi_part is the partial product and lo_part the remaining multiplier bits;
// for divide hi_part is the remainder and lo_part shifts dividend out / quotient in.
module muldiv_iter_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_step,
  input  logic        i_is_div,
  input  logic [31:0] i_op_a,
  input  logic [31:0] i_op_b,
  output logic [63:0] o_prod,
  output logic [31:0] o_quo,
  output logic [31:0] o_rem
);

  logic [63:0] r_acc;
  logic [31:0] r_opb;
  logic [63:0] w_acc_d;
  logic [32:0] w_sum;
  logic [32:0] w_shift;
  logic [31:0] w_sub;
  logic        w_ge;

  always_comb begin
    w_sum   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opb} : 33'd0);
    w_shift = {r_acc[63:32], r_acc[31]};
    w_ge    = (w_shift >= {1'b0, r_opb});
    // When w_ge the true difference is below the divisor, so 32 bits hold it.
    w_sub   = w_shift[31:0] - r_opb;
    w_acc_d = r_acc;
    if (i_start) begin
      w_acc_d = {32'd0, i_op_a};
    end else if (i_step) begin
      if (i_is_div) begin
        w_acc_d = {(w_ge ? w_sub : w_shift[31:0]), r_acc[30:0], w_ge};
      end else begin
        w_acc_d = {w_sum, r_acc[31:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_opb <= '0;
    end else begin
      r_acc <= w_acc_d;
      if (i_start) r_opb <= i_op_b;
    end
  end

  assign o_prod = r_acc;
  assign o_quo  = r_acc[31:0];
  assign o_rem  = r_acc[63:32];

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: owns architectural HI/LO; sequences MULT/MULTU/DIV/DIVU over
// ITERS cycles, services MTHI/MTLO/MFHI/MFLO, and stalls later HI/LO accesses.
//   CLOCK  rising-edge clock
//   RESET  async active-low reset
//   bus    slave side of hilo_muldiv_ctrl_if (instruction in, result/stall/HI/LO out)
module hilo_muldiv_ctrl
  import hilo_pkg::*;
#(
  parameter int unsigned ITERS = ITERS_DEF
) (
  input logic                CLOCK,
  input logic                RESET,
  hilo_muldiv_ctrl_if.slave  bus
);

  localparam int unsigned CntW = (ITERS > 1) ? $clog2(ITERS) : 1;

  state_e          r_state, w_state_d;
  logic [CntW-1:0] r_count, w_count_d;
  logic [31:0]     r_hi, w_hi_d;
  logic [31:0]     r_lo, w_lo_d;
  logic            r_is_div, r_neg_q, r_neg_r, r_dvz;
  logic [31:0]     r_a_raw;

  logic        w_hilo_op, w_start, w_step, w_signed;
  logic [31:0] w_mag_a, w_mag_b;
  logic [63:0] w_prod;
  logic [31:0] w_quo, w_rem;
  logic [5:0]  w_fn;

  assign w_fn      = bus.ALUControl_IN;
  assign w_hilo_op = bus.Valid_IN && is_hilo_op(w_fn);
  assign w_signed  = (w_fn == FN_MULT) || (w_fn == FN_DIV);
  // Two's-complement negate of 0x80000000 gives 0x80000000 = 2^31 as unsigned.
  assign w_mag_a   = (w_signed && bus.OperandA_IN[31]) ? (~bus.OperandA_IN + 32'd1)
                                                       : bus.OperandA_IN;
  assign w_mag_b   = (w_signed && bus.OperandB_IN[31]) ? (~bus.OperandB_IN + 32'd1)
                                                       : bus.OperandB_IN;

  muldiv_iter_core u_core (
    .clk      (CLOCK),
    .rst_n    (RESET),
    .i_start  (w_start),
    .i_step   (w_step),
    .i_is_div (r_is_div),
    .i_op_a   (w_mag_a),
    .i_op_b   (w_mag_b),
    .o_prod   (w_prod),
    .o_quo    (w_quo),
    .o_rem    (w_rem)
  );

  always_comb begin
    w_state_d = r_state;
    w_count_d = r_count;
    w_hi_d    = r_hi;
    w_lo_d    = r_lo;
    w_start   = 1'b0;
    w_step    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_hilo_op && !bus.Flush_IN) begin
          case (w_fn)
            FN_MTHI: w_hi_d = bus.OperandA_IN;
            FN_MTLO: w_lo_d = bus.OperandA_IN;
            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
              w_start   = 1'b1;
              w_count_d = '0;
              w_state_d = RUN;
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        if (bus.Flush_IN) begin
          w_state_d = IDLE;
        end else begin
          w_step    = 1'b1;
          w_count_d = r_count + 1'b1;
          if (r_count == CntW'(ITERS - 1)) w_state_d = FIX;
        end
      end
      FIX: begin
        w_state_d = IDLE;
        if (!bus.Flush_IN) begin
          if (!r_is_div) begin
            {w_hi_d, w_lo_d} = r_neg_q ? (~w_prod + 64'd1) : w_prod;
          end else if (r_dvz) begin
            w_hi_d = r_a_raw;
            w_lo_d = 32'hFFFF_FFFF;
          end else begin
            w_lo_d = r_neg_q ? (~w_quo + 32'd1) : w_quo;
            w_hi_d = r_neg_r ? (~w_rem + 32'd1) : w_rem;
          end
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dvz    <= 1'b0;
      r_a_raw  <= '0;
    end else begin
      r_state <= w_state_d;
      r_count <= w_count_d;
      r_hi    <= w_hi_d;
      r_lo    <= w_lo_d;
      if (w_start) begin
        r_is_div <= (w_fn == FN_DIV) || (w_fn == FN_DIVU);
        r_neg_q  <= w_signed && (bus.OperandA_IN[31] ^ bus.OperandB_IN[31]);
        r_neg_r  <= w_signed && bus.OperandA_IN[31];
        r_dvz    <= (bus.OperandB_IN == 32'd0);
        r_a_raw  <= bus.OperandA_IN;
      end
    end
  end

  assign bus.Busy_OUT   = (r_state != IDLE);
  assign bus.Stall_OUT  = bus.Busy_OUT && w_hilo_op && !bus.Flush_IN;
  assign bus.HI_OUT     = r_hi;
  assign bus.LO_OUT     = r_lo;
  assign bus.Result_OUT = (bus.Valid_IN && w_fn == FN_MFHI) ? r_hi :
                          (bus.Valid_IN && w_fn == FN_MFLO) ? r_lo : 32'd0;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
module tb_hilo_muldiv_ctrl;
  import hilo_pkg::*;

  logic CLOCK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLOCK = ~CLOCK;

  hilo_muldiv_ctrl_if bus ();

  hilo_muldiv_ctrl #(.ITERS(32)) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus)
  );

  typedef struct packed {
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs [NVEC];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  // Issue one mul/div op, count busy cycles, then check latency and HI/LO.
  task automatic run_op(input string tag, input logic [5:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo);
    int cnt;
    bus.Valid_IN      = 1'b1;
    bus.ALUControl_IN = fn;
    bus.OperandA_IN   = a;
    bus.OperandB_IN   = b;
    step();
    bus.Valid_IN      = 1'b0;
    bus.ALUControl_IN = 6'h20;
    cnt = 0;
    while (bus.Busy_OUT && cnt < 100) begin
      cnt++;
      step();
    end
    check({tag, "_busy_cycles"}, cnt, 33);
    check({tag, "_hi"}, bus.HI_OUT, hi);
    check({tag, "_lo"}, bus.LO_OUT, lo);
  endtask

  initial begin
    int sc;
    vecs[0] = '{FN_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[1] = '{FN_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
    vecs[2] = '{FN_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{FN_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[4] = '{FN_DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
    vecs[5] = '{FN_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[6] = '{FN_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
    vecs[7] = '{FN_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8] = '{FN_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[9] = '{FN_MULTU, 32'h12345678, 32'h00010000, 32'h00001234, 32'h56780000};

    bus.Valid_IN      = 1'b0;
    bus.ALUControl_IN = 6'h20;
    bus.OperandA_IN   = '0;
    bus.OperandB_IN   = '0;
    bus.Flush_IN      = 1'b0;

    #12;
    check("rst_hi", bus.HI_OUT, 32'd0);
    check("rst_lo", bus.LO_OUT, 32'd0);
    check("rst_busy", {31'd0, bus.Busy_OUT}, 32'd0);
    check("rst_stall", {31'd0, bus.Stall_OUT}, 32'd0);
    check("rst_result", bus.Result_OUT, 32'd0);
    @(negedge CLOCK);
    RESET = 1'b1;
    step();

    for (int i = 0; i < NVEC; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].fn, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo);
    end

    // MULT 3x5, unrelated ADD during busy, then MFLO stalled until first IDLE cycle.
    bus.Valid_IN = 1'b1; bus.ALUControl_IN = FN_MULT;
    bus.OperandA_IN = 32'd3; bus.OperandB_IN = 32'd5;
    step();
    bus.ALUControl_IN = 6'h20;
    @(negedge CLOCK);
    check("add_no_stall", {31'd0, bus.Stall_OUT}, 32'd0);
    step();
    bus.ALUControl_IN = FN_MFLO;
    sc = 0;
    @(negedge CLOCK);
    while (bus.Stall_OUT && sc < 100) begin
      sc++;
      step();
      @(negedge CLOCK);
    end
    check("mflo_stall_cycles", sc, 32);
    check("mflo_result", bus.Result_OUT, 32'h0000000F);
    check("mflo_busy_low", {31'd0, bus.Busy_OUT}, 32'd0);
    step();
    bus.Valid_IN = 1'b0; bus.ALUControl_IN = 6'h20;

    // MTHI then MFHI back-to-back; MTLO then MFLO.
    bus.Valid_IN = 1'b1; bus.ALUControl_IN = FN_MTHI; bus.OperandA_IN = 32'hDEADBEEF;
    step();
    bus.ALUControl_IN = FN_MFHI; bus.OperandA_IN = 32'd0;
    @(negedge CLOCK);
    check("mfhi_result", bus.Result_OUT, 32'hDEADBEEF);
    check("mfhi_no_stall", {31'd0, bus.Stall_OUT}, 32'd0);
    step();
    bus.ALUControl_IN = FN_MTLO; bus.OperandA_IN = 32'hCAFEF00D;
    step();
    bus.ALUControl_IN = FN_MFLO;
    @(negedge CLOCK);
    check("mflo_after_mtlo", bus.Result_OUT, 32'hCAFEF00D);
    step();

    // Flush in IDLE beats a simultaneous MTLO.
    bus.ALUControl_IN = FN_MTLO; bus.OperandA_IN = 32'h11111111; bus.Flush_IN = 1'b1;
    step();
    bus.Flush_IN = 1'b0; bus.Valid_IN = 1'b0; bus.ALUControl_IN = 6'h20;
    check("idle_flush_lo", bus.LO_OUT, 32'hCAFEF00D);

    // Flush at RUN cycle 10 of DIV.
    bus.Valid_IN = 1'b1; bus.ALUControl_IN = FN_DIV;
    bus.OperandA_IN = 32'd100; bus.OperandB_IN = 32'd7;
    step();
    bus.Valid_IN = 1'b0; bus.ALUControl_IN = 6'h20;
    repeat (9) step();
    check("flush_busy_before", {31'd0, bus.Busy_OUT}, 32'd1);
    bus.Flush_IN = 1'b1;
    step();
    bus.Flush_IN = 1'b0;
    check("flush_busy_after", {31'd0, bus.Busy_OUT}, 32'd0);
    check("flush_hi", bus.HI_OUT, 32'hDEADBEEF);
    check("flush_lo", bus.LO_OUT, 32'hCAFEF00D);
    repeat (40) step();
    check("flush_lo_later", bus.LO_OUT, 32'hCAFEF00D);

    // Async reset at RUN cycle 5, then MULTU 2x2.
    bus.Valid_IN = 1'b1; bus.ALUControl_IN = FN_MULTU;
    bus.OperandA_IN = 32'd9; bus.OperandB_IN = 32'd9;
    step();
    bus.Valid_IN = 1'b0; bus.ALUControl_IN = 6'h20;
    repeat (5) step();
    RESET = 1'b0;
    #1;
    check("midrst_hi", bus.HI_OUT, 32'd0);
    check("midrst_lo", bus.LO_OUT, 32'd0);
    check("midrst_busy", {31'd0, bus.Busy_OUT}, 32'd0);
    @(negedge CLOCK);
    RESET = 1'b1;
    step();
    check("postrst_busy", {31'd0, bus.Busy_OUT}, 32'd0);
    run_op("postrst_multu", FN_MULTU, 32'd2, 32'd2, 32'd0, 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected normal completion");
    $fatal(1);
  end

endmodule
